// File: rtl/hamming_encoder_stream_pkg.sv
// Width helpers for the SECDED Hamming encoder/checker pair, all derived
// from the number of Hamming parity bits (overall parity bit not included).
package hamming_encoder_stream_pkg;

   function automatic int cw_width(input int p_bits);
      return 1 << p_bits;
   endfunction

   function automatic int data_width(input int p_bits);
      return (1 << p_bits) - p_bits - 1;
   endfunction

   // Positions 1, 2, 4, ... carry Hamming parity; position 0 is overall parity.
   function automatic logic is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

endpackage

// File: rtl/hamming_encoder_stream_gen.sv
// Purely combinational SECDED encoder: scatters data onto non-power-of-two
// positions, fills the Hamming parity bits, then sets even overall parity.
module hamming_gen
   import hamming_encoder_stream_pkg::*;
#(
   parameter int P_BITS  = 3,
   parameter int CW_MSB  = cw_width(P_BITS) - 1,
   parameter int D_WIDTH = data_width(P_BITS)
) (
   input  logic [D_WIDTH-1:0] in_data,
   output logic [CW_MSB:0]    out_code
);

   logic [CW_MSB:0] w_code;

   always_comb begin
      int   d_idx;
      logic p;
      w_code = '0;
      d_idx  = 0;
      p      = 1'b0;
      for (int j = 1; j <= CW_MSB; j++) begin
         if (!is_pow2(j)) begin
            w_code[j] = in_data[d_idx];
            d_idx++;
         end
      end
      // Parity slot 2^k is still zero while its own group is summed.
      for (int k = 0; k < P_BITS; k++) begin
         p = 1'b0;
         for (int j = 1; j <= CW_MSB; j++) begin
            if (((j >> k) & 1) == 1) p = p ^ w_code[j];
         end
         w_code[1 << k] = p;
      end
      w_code[0] = ^w_code[CW_MSB:1];
   end

   assign out_code = w_code;

endmodule

// File: rtl/hamming_encoder_stream.sv
// Streaming SECDED encoder: combinational encode, one-shot error injection,
// 2-entry output FIFO and an accepted-word counter.
module hamming_encoder_stream
   import hamming_encoder_stream_pkg::*;
#(
   parameter int P_BITS  = 3,
   parameter int CW_MSB  = cw_width(P_BITS) - 1,
   parameter int D_WIDTH = data_width(P_BITS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CW_MSB:0]    out_code,
   input  logic               inj_arm,
   input  logic [CW_MSB:0]    inj_mask,
   output logic [15:0]        word_cnt
);

   // Handshake: a word moves only on a rising edge where valid and ready are
   // both high; in_ready depends on FIFO occupancy alone, never on out_ready.
   logic [CW_MSB:0] r_mem [0:1];
   logic            r_wr_ptr;
   logic            r_rd_ptr;
   logic [1:0]      r_count;
   logic            r_armed;
   logic [CW_MSB:0] r_mask;
   logic [15:0]     r_word_cnt;

   logic [CW_MSB:0] w_code;
   logic [CW_MSB:0] w_store;
   logic            w_push;
   logic            w_pop;
   logic            w_inject;

   hamming_gen #(
      .P_BITS  (P_BITS),
      .CW_MSB  (CW_MSB),
      .D_WIDTH (D_WIDTH)
   ) u_gen (
      .in_data  (in_data),
      .out_code (w_code)
   );

   assign w_push   = in_valid & in_ready;
   assign w_pop    = out_valid & out_ready;
   // A word arriving on the arm edge itself stays clean; the arm applies later.
   assign w_inject = w_push & r_armed & ~inj_arm;
   assign w_store  = w_inject ? (w_code ^ r_mask) : w_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_store;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_mask  <= '0;
      end else if (inj_arm) begin
         r_armed <= 1'b1;
         r_mask  <= inj_mask;
      end else if (w_inject) begin
         r_armed <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_word_cnt <= 16'd0;
      else if (w_push) r_word_cnt <= r_word_cnt + 16'd1;
   end

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_code  = r_mem[r_rd_ptr];
   assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Bench for hamming_encoder_stream (P_BITS=3): vector table, hand sequences
// for backpressure/injection/reset, and a queue scoreboard on every cycle.
module tb_hamming_encoder_stream;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic       inj_arm;
   logic [7:0] inj_mask;
   logic [15:0] word_cnt;

   int n_checks;
   int n_errors;

   logic [7:0] exp_q[$];
   logic       m_armed;
   logic [7:0] m_mask;
   logic [15:0] m_cnt;

   typedef struct {
      logic [3:0] data;
      logic [7:0] code;
   } vec_t;
   vec_t vecs[7];

   hamming_encoder_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .inj_arm   (inj_arm),
      .inj_mask  (inj_mask),
      .word_cnt  (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference encoder written out as explicit parity equations.
   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [7:0] c;
      c    = 8'h00;
      c[3] = d[0];
      c[5] = d[1];
      c[6] = d[2];
      c[7] = d[3];
      c[1] = d[0] ^ d[1] ^ d[3];
      c[2] = d[0] ^ d[2] ^ d[3];
      c[4] = d[1] ^ d[2] ^ d[3];
      c[0] = ^c[7:1];
      return c;
   endfunction

   // Checker model: {syndrome[2:0], overall parity, data[3:0]}.
   function automatic logic [7:0] check_cw(input logic [7:0] c);
      logic [2:0] s;
      s[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
      s[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
      s[2] = c[4] ^ c[5] ^ c[6] ^ c[7];
      return {s, ^c, c[7], c[6], c[5], c[3]};
   endfunction

   // Scoreboard: queue length mirrors FIFO occupancy; expected codes pushed on accept.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n) begin
         chk("mon_word_cnt", word_cnt, m_cnt);
         chk("mon_in_ready", 16'(in_ready), 16'(exp_q.size() < 2));
         chk("mon_out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
         if (out_valid && exp_q.size() != 0)
            chk("mon_out_code", 16'(out_code), 16'(exp_q[0]));
         if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) begin
            e = enc(in_data);
            if (m_armed && !inj_arm) begin
               e       = e ^ m_mask;
               m_armed = 1'b0;
            end
            exp_q.push_back(e);
            m_cnt = m_cnt + 16'd1;
         end
         if (inj_arm) begin
            m_armed = 1'b1;
            m_mask  = inj_mask;
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      m_armed = 1'b0;
      m_mask  = 8'h00;
      m_cnt   = 16'd0;
   endtask

   // Offer one word; returns at posedge+1 just after it was accepted.
   task automatic send(input logic [3:0] d);
      int t;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t == 20) chk("send_timeout", 16'(in_ready), 16'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      n_checks = 0;
      n_errors = 0;
      vecs[0] = '{4'hB, 8'hAA};
      vecs[1] = '{4'h0, 8'h00};
      vecs[2] = '{4'hF, 8'hFF};
      vecs[3] = '{4'h1, 8'h0F};
      vecs[4] = '{4'h2, 8'h33};
      vecs[5] = '{4'h4, 8'h55};
      vecs[6] = '{4'h8, 8'h96};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
      inj_arm = 1'b0; inj_mask = 8'h00;
      model_reset();
      #1;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_in_ready", 16'(in_ready), 16'd1);
      chk("rst_word_cnt", word_cnt, 16'd0);
      chk("rst_out_code", 16'(out_code), 16'h00);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Table vectors: one cycle latency from accept to out_valid.
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(vecs[i].data);
         @(negedge clk);
         chk("tbl_valid", 16'(out_valid), 16'd1);
         chk("tbl_code", 16'(out_code), 16'(vecs[i].code));
      end

      // All data values round-trip through the checker model.
      for (int d = 0; d < 16; d++) begin
         send(4'(d));
         @(negedge clk);
         r = check_cw(out_code);
         chk("sweep_data", 16'(r[3:0]), 16'(d));
         chk("sweep_syn_par", 16'(r[7:4]), 16'd0);
      end

      // Backpressure: two accepted, third waits for a pop.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h3;
      @(posedge clk); #1 in_data = 4'h5;
      @(posedge clk); #1 in_data = 4'h9;
      @(posedge clk); #1;
      chk("bp_in_ready_full", 16'(in_ready), 16'd0);
      chk("bp_word_cnt2", word_cnt, m_cnt);
      chk("bp_head", 16'(out_code), 16'(enc(4'h3)));
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ready_after_pop", 16'(in_ready), 16'd1);
      chk("bp_third_not_yet", word_cnt, m_cnt);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_third_accepted", 16'(word_cnt - m_cnt), 16'd0);
      chk("bp_head_after", 16'(out_code), 16'(enc(4'h9)));
      repeat (3) @(posedge clk);

      // Injection: next word after the arm edge is flipped, following one clean.
      #1 inj_arm = 1'b1; inj_mask = 8'h04;
      @(posedge clk); #1 inj_arm = 1'b0; inj_mask = 8'h00;
      send(4'hB);
      @(negedge clk);
      chk("inj_code", 16'(out_code), 16'h00AE);
      send(4'hB);
      @(negedge clk);
      chk("inj_next_clean", 16'(out_code), 16'h00AA);

      // Word on the arm edge stays clean, the following one is injected.
      @(posedge clk); #1;
      inj_arm = 1'b1; inj_mask = 8'h80; in_valid = 1'b1; in_data = 4'h0;
      @(posedge clk); #1;
      inj_arm = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("arm_edge_clean", 16'(out_code), 16'h0000);
      send(4'h0);
      @(negedge clk);
      chk("arm_later_inj", 16'(out_code), 16'h0080);

      // Double-bit injection is seen as a double error.
      @(posedge clk); #1;
      out_ready = 1'b0; inj_arm = 1'b1; inj_mask = 8'h06;
      @(posedge clk); #1 inj_arm = 1'b0;
      send(4'h6);
      @(negedge clk);
      r = check_cw(out_code);
      chk("dbl_par", 16'(r[4]), 16'd0);
      chk("dbl_syn_nz", 16'(r[7:5] != 3'd0), 16'd1);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);

      // Mid-stream reset with two words buffered and an arm pending.
      #1 out_ready = 1'b0;
      send(4'h1);
      send(4'h2);
      inj_arm = 1'b1; inj_mask = 8'hFF;
      @(posedge clk); #1 inj_arm = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mrst_out_valid", 16'(out_valid), 16'd0);
      chk("mrst_word_cnt", word_cnt, 16'd0);
      chk("mrst_in_ready", 16'(in_ready), 16'd1);
      chk("mrst_out_code", 16'(out_code), 16'h00);
      #5 rst_n = 1'b1;
      out_ready = 1'b1;
      send(4'hB);
      @(negedge clk);
      chk("post_rst_clean", 16'(out_code), 16'h00AA);
      chk("post_rst_cnt", word_cnt, 16'd1);

      // Random traffic with occasional arms; scoreboard checks each cycle.
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         inj_arm   = ($urandom_range(0, 9) == 0);
         inj_mask  = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      in_valid = 1'b0; inj_arm = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("final_drained", 16'(exp_q.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
